mmio_unit: RTL and testbench

Memory-mapped I/O block sitting beside data memory, downstream of the execute stage. It consumes the EX-stage load/store address and data, and holds the cycle and instruction counters. It buffers UART traffic in TX and RX FIFOs so software can burst bytes without polling per byte. Load data is registered, so it reaches the MEM/WB stage with the same 1-cycle latency as the data BRAM.

---
 rtl/mmio_pkg.sv | 15 +
 rtl/sync_fifo.sv | 59 +++++
 rtl/mmio_unit.sv | 142 ++++++++++++++
 tb/tb_mmio_unit.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - MMIO register offsets and control-word bit positions
package mmio_pkg;

    localparam logic [7:0] MMIO_CTRL   = 8'h00;
    localparam logic [7:0] MMIO_RXDATA = 8'h04;
    localparam logic [7:0] MMIO_TXDATA = 8'h08;
    localparam logic [7:0] MMIO_CYCLE  = 8'h10;
    localparam logic [7:0] MMIO_INSTR  = 8'h14;
    localparam logic [7:0] MMIO_CNTRST = 8'h18;

    localparam int TX_NOT_FULL  = 0;
    localparam int RX_NOT_EMPTY = 1;
    localparam int TX_OVF       = 2;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock first-word-fall-through FIFO
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // A full FIFO still takes a push when the same cycle frees a slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_unit.sv
// rtl/mmio_unit.sv - MMIO window with cycle/instr counters and UART TX/RX FIFOs
module mmio_unit
    import mmio_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        kill,
    input  logic        inst_retire,
    output logic        hit,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    offset;
    logic          accept;
    logic          load_acc;
    logic          tx_push_req;
    logic          rx_pop_req;
    logic          ctrl_rd;
    logic          cnt_clr;
    logic          tx_pop;
    logic          tx_full;
    logic          tx_empty;
    logic          rx_full;
    logic          rx_empty;
    logic [7:0]    rx_head;
    logic [CW-1:0] tx_count;
    logic [CW-1:0] rx_count;
    logic          tx_ovf;
    logic [31:0]   cycle_counter;
    logic [31:0]   instr_counter;
    logic [31:0]   ctrl_word;
    logic [31:0]   load_data;
    logic          unused_bits;

    assign offset      = req_addr[7:0];
    assign hit         = req_valid && (req_addr[31:8] == BASE_ADDR[31:8]);
    assign accept      = hit && !kill;
    assign load_acc    = accept && !req_we;
    assign ctrl_rd     = load_acc && (offset == MMIO_CTRL);
    assign rx_pop_req  = load_acc && (offset == MMIO_RXDATA);
    assign tx_push_req = accept && req_we && (offset == MMIO_TXDATA);
    assign cnt_clr     = accept && req_we && (offset == MMIO_CNTRST);

    assign uart_tx_valid = !tx_empty;
    assign uart_rx_ready = !rx_full;
    assign tx_pop        = uart_tx_valid && uart_tx_ready;
    assign unused_bits   = ^{req_wdata[31:8], tx_count, rx_count};

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push_req),
        .din   (req_wdata[7:0]),
        .pop   (tx_pop),
        .dout  (uart_tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (uart_rx_valid && uart_rx_ready),
        .din   (uart_rx_data),
        .pop   (rx_pop_req),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    always_comb begin
        ctrl_word               = '0;
        ctrl_word[TX_NOT_FULL]  = !tx_full;
        ctrl_word[RX_NOT_EMPTY] = !rx_empty;
        ctrl_word[TX_OVF]       = tx_ovf;
    end

    always_comb begin
        load_data = '0;
        case (offset)
            MMIO_CTRL:   load_data = ctrl_word;
            MMIO_RXDATA: load_data = rx_empty ? 32'h0 : {24'h0, rx_head};
            MMIO_CYCLE:  load_data = cycle_counter;
            MMIO_INSTR:  load_data = instr_counter;
            default:     load_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata       <= '0;
            rdata_valid <= 1'b0;
        end else begin
            rdata_valid <= load_acc;
            if (load_acc) begin
                rdata <= load_data;
            end
        end
    end

    // Overflow is sticky until software reads the control word.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_ovf <= 1'b0;
        end else if (tx_push_req && tx_full && !tx_pop) begin
            tx_ovf <= 1'b1;
        end else if (ctrl_rd) begin
            tx_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cycle_counter <= '0;
            instr_counter <= '0;
        end else begin
            cycle_counter <= cycle_counter + 32'd1;
            if (inst_retire) begin
                instr_counter <= instr_counter + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_mmio_unit.sv
// tb/tb_mmio_unit.sv - directed self-checking bench for mmio_unit
module tb_mmio_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        kill;
    logic        inst_retire;
    logic        hit;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;

    int pass_cnt = 0;
    int total_cnt = 0;

    mmio_unit #(.FIFO_DEPTH(8), .BASE_ADDR(32'h8000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .kill          (kill),
        .inst_retire   (inst_retire),
        .hit           (hit),
        .rdata         (rdata),
        .rdata_valid   (rdata_valid),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] addr);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = addr;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = addr;
        req_wdata = data;
        tick();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total_cnt++;
        if (rdata !== 32'h0 || rdata_valid !== 1'b0) $display("FAIL reset_rdata: got %h/%b want 0/0", rdata, rdata_valid);
        else pass_cnt++;
        total_cnt++;
        if (uart_tx_valid !== 1'b0 || uart_rx_ready !== 1'b1) $display("FAIL reset_uart: got tx_valid=%b rx_ready=%b want 0/1", uart_tx_valid, uart_rx_ready);
        else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_counters();
        for (int i = 0; i < 5; i++) begin
            inst_retire = (i % 2 == 0);
            tick();
        end
        inst_retire = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h8000_0010;
        #1;
        total_cnt++;
        if (hit !== 1'b1) $display("FAIL hit_window: got %b want 1", hit);
        else pass_cnt++;
        tick();
        req_valid = 1'b0;
        total_cnt++;
        if (rdata !== 32'd5 || rdata_valid !== 1'b1) $display("FAIL cycle_count: got %0d/%b want 5/1", rdata, rdata_valid);
        else pass_cnt++;
        do_load(32'h8000_0014);
        total_cnt++;
        if (rdata !== 32'd3) $display("FAIL instr_count: got %0d want 3", rdata);
        else pass_cnt++;
        req_addr = 32'h8000_0110;
        req_valid = 1'b1;
        #1;
        total_cnt++;
        if (hit !== 1'b0) $display("FAIL hit_outside: got %b want 0", hit);
        else pass_cnt++;
        req_valid = 1'b0;
        tick();
    endtask

    task automatic test_tx_basic();
        logic [7:0] exp_b [3] = '{8'h41, 8'h42, 8'h43};
        uart_tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) do_store(32'h8000_0008, {24'h0, exp_b[i]});
        do_load(32'h8000_0000);
        total_cnt++;
        if (rdata !== 32'h1) $display("FAIL tx_ctrl: got %h want 1", rdata);
        else pass_cnt++;
        uart_tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (uart_tx_valid !== 1'b1 || uart_tx_data !== exp_b[i]) $display("FAIL tx_byte%0d: got %b/%h want 1/%h", i, uart_tx_valid, uart_tx_data, exp_b[i]);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (uart_tx_valid !== 1'b0) $display("FAIL tx_drained: got %b want 0", uart_tx_valid);
        else pass_cnt++;
        uart_tx_ready = 1'b0;
    endtask

    task automatic test_tx_overflow();
        int drained;
        for (int i = 0; i < 9; i++) do_store(32'h8000_0008, 32'h10 + i);
        do_load(32'h8000_0000);
        total_cnt++;
        if (rdata !== 32'h4) $display("FAIL ovf_ctrl: got %h want 4", rdata);
        else pass_cnt++;
        do_load(32'h8000_0000);
        total_cnt++;
        if (rdata !== 32'h0) $display("FAIL ovf_clear: got %h want 0", rdata);
        else pass_cnt++;
        uart_tx_ready = 1'b1;
        drained = 0;
        for (int i = 0; i < 12 && uart_tx_valid; i++) begin
            if (uart_tx_data !== 8'(8'h10 + i)) $display("FAIL ovf_data%0d: got %h want %h", i, uart_tx_data, 8'(8'h10 + i));
            drained++;
            tick();
        end
        total_cnt++;
        if (drained !== 8) $display("FAIL ovf_drain_count: got %0d want 8", drained);
        else pass_cnt++;
        uart_tx_ready = 1'b0;
    endtask

    task automatic test_rx();
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'h55;
        tick();
        uart_rx_data  = 8'hAA;
        tick();
        uart_rx_valid = 1'b0;
        do_load(32'h8000_0000);
        total_cnt++;
        if (rdata !== 32'h3) $display("FAIL rx_ctrl: got %h want 3", rdata);
        else pass_cnt++;
        do_load(32'h8000_0004);
        total_cnt++;
        if (rdata !== 32'h55) $display("FAIL rx_first: got %h want 55", rdata);
        else pass_cnt++;
        do_load(32'h8000_0004);
        total_cnt++;
        if (rdata !== 32'hAA) $display("FAIL rx_second: got %h want aa", rdata);
        else pass_cnt++;
        do_load(32'h8000_0004);
        total_cnt++;
        if (rdata !== 32'h0 || rdata_valid !== 1'b1) $display("FAIL rx_empty_read: got %h/%b want 0/1", rdata, rdata_valid);
        else pass_cnt++;
        do_load(32'h8000_0000);
        total_cnt++;
        if (rdata !== 32'h1) $display("FAIL rx_ctrl_after: got %h want 1", rdata);
        else pass_cnt++;
    endtask

    task automatic test_kill_and_clear();
        kill = 1'b1;
        do_store(32'h8000_0008, 32'h99);
        kill = 1'b0;
        total_cnt++;
        if (uart_tx_valid !== 1'b0) $display("FAIL kill_push: got tx_valid=%b want 0", uart_tx_valid);
        else pass_cnt++;
        do_store(32'h8000_0018, 32'hDEAD);
        do_load(32'h8000_0010);
        total_cnt++;
        if (rdata !== 32'd0) $display("FAIL clear_first: got %0d want 0", rdata);
        else pass_cnt++;
        inst_retire = 1'b1;
        for (int i = 0; i < 98; i++) tick();
        do_store(32'h8000_0018, 32'h0);
        inst_retire = 1'b0;
        do_load(32'h8000_0010);
        total_cnt++;
        if (rdata !== 32'd0) $display("FAIL clear_cycle: got %0d want 0", rdata);
        else pass_cnt++;
        do_load(32'h8000_0014);
        total_cnt++;
        if (rdata !== 32'd0) $display("FAIL clear_instr: got %0d want 0", rdata);
        else pass_cnt++;
        do_load(32'h8000_0010);
        total_cnt++;
        if (rdata !== 32'd2) $display("FAIL cycle_resume: got %0d want 2", rdata);
        else pass_cnt++;
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_b [8] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h7E};
        uart_tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) do_store(32'h8000_0008, 32'h60 + i);
        uart_tx_ready = 1'b1;
        do_store(32'h8000_0008, 32'h7E);
        uart_tx_ready = 1'b0;
        do_load(32'h8000_0000);
        total_cnt++;
        if (rdata !== 32'h0) $display("FAIL full_pushpop_ctrl: got %h want 0", rdata);
        else pass_cnt++;
        uart_tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total_cnt++;
            if (uart_tx_valid !== 1'b1 || uart_tx_data !== exp_b[i]) $display("FAIL full_seq%0d: got %b/%h want 1/%h", i, uart_tx_valid, uart_tx_data, exp_b[i]);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (uart_tx_valid !== 1'b0) $display("FAIL full_drained: got %b want 0", uart_tx_valid);
        else pass_cnt++;
        uart_tx_ready = 1'b0;
    endtask

    task automatic test_reset_midstream();
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'h33;
        for (int i = 0; i < 3; i++) do_store(32'h8000_0008, 32'hA0 + i);
        uart_rx_valid = 1'b0;
        uart_tx_ready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        uart_tx_ready = 1'b0;
        total_cnt++;
        if (uart_tx_valid !== 1'b0) $display("FAIL rst_mid_tx: got %b want 0", uart_tx_valid);
        else pass_cnt++;
        do_load(32'h8000_0000);
        total_cnt++;
        if (rdata !== 32'h1) $display("FAIL rst_mid_ctrl: got %h want 1", rdata);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        kill = 1'b0;
        inst_retire = 1'b0;
        uart_tx_ready = 1'b0;
        uart_rx_data = '0;
        uart_rx_valid = 1'b0;
        test_reset();
        test_counters();
        test_tx_basic();
        test_tx_overflow();
        test_rx();
        test_kill_and_clear();
        test_full_push_pop();
        test_reset_midstream();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
